// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode and FSM enums plus the fixed divide corner-case results.
package alu_pkg;

    localparam int OP_W  = 5;
    localparam int MAX_W = 64;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_LT     = 5'd8,
        OP_LTU    = 5'd9,
        OP_NOP    = 5'd10,
        OP_MUL    = 5'd11,
        OP_MULH   = 5'd12,
        OP_MULHSU = 5'd13,
        OP_MULHU  = 5'd14,
        OP_DIV    = 5'd15,
        OP_DIVU   = 5'd16,
        OP_REM    = 5'd17,
        OP_REMU   = 5'd18
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Quotient on divide-by-zero is all ones; remainder on signed overflow is zero.
    // Sliced down to the datapath width by the user.
    localparam logic [MAX_W-1:0] DIVZ_QUO = {MAX_W{1'b1}};
    localparam logic [MAX_W-1:0] OVF_REM  = {MAX_W{1'b0}};

endpackage

// File: rtl/md_iter.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply, restoring divide,
// one step per cycle for WIDTH cycles. Operates on magnitudes and fixes signs at the end.
// Divider present only when ALU_MD_DIV_EN is defined.
module md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             div_i,
    input  logic             s1_i,
    input  logic             s2_i,
    input  logic             hi_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, p_q, a_d, p_d;
    logic [WIDTH-1:0] abs1, abs2, mul_res;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic             neg_q, hi_q, sg1, sg2, go_div;

    assign sg1    = s1_i & a_i[WIDTH-1];
    assign sg2    = s2_i & b_i[WIDTH-1];
    assign abs1   = sg1 ? -a_i : a_i;
    assign abs2   = sg2 ? -b_i : b_i;
    assign done_o = busy_q & (cnt_q == CW'(WIDTH-1));

    // Multiply step: p:a holds the running product, a also shifts out multiplier bits.
    assign mul_sum = {1'b0, p_q} + ({(WIDTH+1){a_q[0]}} & {1'b0, b_q});

    // Result sees the final step's next values so it lands in the same edge as done.
    assign prod    = {p_d, a_d};
    assign prod_s  = neg_q ? -prod : prod;
    assign mul_res = hi_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];

`ifdef ALU_MD_DIV_EN
    logic             div_q, negr_q, divz_q, ovf_q;
    logic [WIDTH-1:0] a_raw_q, quo, rem;
    logic [WIDTH:0]   rem_sh, diff;

    assign go_div = div_i;

    // Divide-only side state: remainder sign, corner-case flags and raw dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_raw_q <= '0;
        end else if (start_i && !abort_i) begin
            div_q   <= div_i;
            negr_q  <= sg1;
            divz_q  <= (b_i == '0);
            ovf_q   <= s1_i & s2_i & (a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (b_i == '1);
            a_raw_q <= a_i;
        end
    end

    // One iteration: restoring-divide step or shift-add multiply step.
    always_comb begin
        rem_sh = {p_q, a_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        p_d    = mul_sum[WIDTH:1];
        a_d    = {mul_sum[0], a_q[WIDTH-1:1]};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                p_d = diff[WIDTH-1:0];
                a_d = {a_q[WIDTH-2:0], 1'b1};
            end else begin
                p_d = rem_sh[WIDTH-1:0];
                a_d = {a_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and divide corner cases.
    always_comb begin
        quo = neg_q ? -a_d : a_d;
        rem = negr_q ? -p_d : p_d;
        if (divz_q) begin
            quo = DIVZ_QUO[WIDTH-1:0];
            rem = a_raw_q;
        end else if (ovf_q) begin
            quo = a_raw_q;
            rem = OVF_REM[WIDTH-1:0];
        end
        res_o = mul_res;
        if (div_q) res_o = hi_q ? rem : quo;
    end
`else
    logic unused_div;

    assign unused_div = div_i;
    assign go_div     = 1'b0;
    assign p_d        = mul_sum[WIDTH:1];
    assign a_d        = {mul_sum[0], a_q[WIDTH-1:1]};
    assign res_o      = mul_res;
`endif

    // Operand load at start, one step per busy cycle, abort drops the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            neg_q  <= 1'b0;
            hi_q   <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            p_q    <= '0;
            neg_q  <= sg1 ^ sg2;
            hi_q   <= hi_i;
            if (go_div) begin
                a_q <= abs1;
                b_q <= abs2;
            end else begin
                a_q <= abs2;
                b_q <= abs1;
            end
        end else if (busy_q) begin
            p_q   <= p_d;
            a_q   <= a_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_md.sv
// ALU with single-cycle ops and iterative multiply/divide behind a valid/ready handshake.
// Define ALU_MD_DIV_EN to include the divider; otherwise DIV/DIVU/REM/REMU report err.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = alu_pkg::OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [OP_W-1:0]  op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             err
);

    localparam int SW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d, alu_res, md_res;
    logic             err_q, err_d;
    logic             accept, is_iter, undef, md_start, md_done;
    logic             md_div, md_s1, md_s2, md_hi;
    logic [SW-1:0]    sh;
    op_e              op_s;

    assign op_s      = op_e'(op);
    assign sh        = in2[SW-1:0];
    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign md_start  = accept & is_iter;
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign err       = err_q;

    // Opcode decode: single-cycle result plus controls for the iterative unit.
    always_comb begin
        alu_res = '0;
        is_iter = 1'b0;
        undef   = 1'b0;
        md_div  = 1'b0;
        md_s1   = 1'b0;
        md_s2   = 1'b0;
        md_hi   = 1'b0;
        case (op_s)
            OP_ADD:    alu_res = in1 + in2;
            OP_SUB:    alu_res = in1 - in2;
            OP_AND:    alu_res = in1 & in2;
            OP_OR:     alu_res = in1 | in2;
            OP_XOR:    alu_res = in1 ^ in2;
            OP_SLL:    alu_res = in1 << sh;
            OP_SRL:    alu_res = in1 >> sh;
            OP_SRA:    alu_res = $signed(in1) >>> sh;
            OP_LT:     alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_LTU:    alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_NOP:    alu_res = '0;
            OP_MUL:    is_iter = 1'b1;
            OP_MULH:   begin is_iter = 1'b1; md_s1 = 1'b1; md_s2 = 1'b1; md_hi = 1'b1; end
            OP_MULHSU: begin is_iter = 1'b1; md_s1 = 1'b1; md_hi = 1'b1; end
            OP_MULHU:  begin is_iter = 1'b1; md_hi = 1'b1; end
`ifdef ALU_MD_DIV_EN
            OP_DIV:    begin is_iter = 1'b1; md_div = 1'b1; md_s1 = 1'b1; md_s2 = 1'b1; end
            OP_DIVU:   begin is_iter = 1'b1; md_div = 1'b1; end
            OP_REM:    begin is_iter = 1'b1; md_div = 1'b1; md_s1 = 1'b1; md_s2 = 1'b1; md_hi = 1'b1; end
            OP_REMU:   begin is_iter = 1'b1; md_div = 1'b1; md_hi = 1'b1; end
`endif
            default:   undef = 1'b1;
        endcase
    end

    md_iter #(.WIDTH(WIDTH)) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (md_start),
        .abort_i (flush),
        .div_i   (md_div),
        .s1_i    (md_s1),
        .s2_i    (md_s2),
        .hi_i    (md_hi),
        .a_i     (in1),
        .b_i     (in2),
        .done_o  (md_done),
        .res_o   (md_res)
    );

    // Next state and result capture; flush wins over everything including a new accept.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        err_d   = err_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_iter) begin
                            state_d = ST_BUSY;
                        end else begin
                            state_d = ST_DONE;
                            out_d   = alu_res;
                            err_d   = undef;
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state_d = ST_DONE;
                        out_d   = md_res;
                        err_d   = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32): scoreboard model plus directed vectors.
module tb_alu_md;
    import alu_pkg::*;

    localparam int W = 32;

`ifdef ALU_MD_DIV_EN
    localparam int DL = W + 1;
`else
    localparam int DL = 1;
`endif

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in1 = '0, in2 = '0;
    logic [4:0]   op = '0;
    logic         in_ready, out_valid, err;
    logic [W-1:0] out;

    int n_chk = 0, n_fail = 0;

    typedef struct { logic [W-1:0] r; logic e; } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .err(err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, expv);
        end
    endtask

    // Reference behaviour from plain 64-bit arithmetic.
    function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   x;
        longint sa, sb;
        logic [63:0] ua, ub, p;
        logic [4:0]  s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        s  = b[4:0];
        x.r = '0;
        x.e = 1'b0;
        case (o)
            OP_ADD:    x.r = a + b;
            OP_SUB:    x.r = a - b;
            OP_AND:    x.r = a & b;
            OP_OR:     x.r = a | b;
            OP_XOR:    x.r = a ^ b;
            OP_SLL:    x.r = a << s;
            OP_SRL:    x.r = a >> s;
            OP_SRA:    begin p = sa >>> s; x.r = p[31:0]; end
            OP_LT:     x.r = (sa < sb) ? 32'd1 : 32'd0;
            OP_LTU:    x.r = (ua < ub) ? 32'd1 : 32'd0;
            OP_NOP:    x.r = '0;
            OP_MUL:    begin p = ua * ub; x.r = p[31:0]; end
            OP_MULH:   begin p = sa * sb; x.r = p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); x.r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub; x.r = p[63:32]; end
`ifdef ALU_MD_DIV_EN
            OP_DIV:  begin
                if (b == 0) x.r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) x.r = a;
                else begin p = sa / sb; x.r = p[31:0]; end
            end
            OP_DIVU: x.r = (b == 0) ? '1 : a / b;
            OP_REM:  begin
                if (b == 0) x.r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) x.r = '0;
                else begin p = sa % sb; x.r = p[31:0]; end
            end
            OP_REMU: x.r = (b == 0) ? a : a % b;
`endif
            default: x.e = 1'b1;
        endcase
        return x;
    endfunction

    // Scoreboard bookkeeping on handshakes; flush and reset discard everything in flight.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q.delete();
        else if (flush) exp_q.delete();
        else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(model(op, in1, in2));
        end
    end

    // Every cycle a result is presented, it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_valid: out_valid=1 with no op outstanding, required 0");
            end else begin
                chk("sb_out", out, exp_q[0].r);
                chk("sb_err", err, exp_q[0].e);
            end
        end
    end

    task automatic run_op(input string nm, input logic [4:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ee,
                          input int elat);
        int lat;
        in_valid = 1'b1; op = o; in1 = a; in2 = b; out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in1 = $urandom; in2 = $urandom; op = 5'($urandom);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_out"}, out, er);
        chk({nm, "_err"}, err, ee);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] bo[6];
        int k, seen;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        run_op("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0, 1);
        run_op("sra",      OP_SRA,  32'h8000_0000, 32'h24,       32'hF800_0000, 1'b0, 1);
        run_op("sub",      OP_SUB,  32'd5,         32'd7,        32'hFFFF_FFFE, 1'b0, 1);
        run_op("and",      OP_AND,  32'hF0F0,      32'hFF00,     32'hF000,      1'b0, 1);
        run_op("or",       OP_OR,   32'hF0F0,      32'h0F0F,     32'hFFFF,      1'b0, 1);
        run_op("xor",      OP_XOR,  32'hFF,        32'h0F,       32'hF0,        1'b0, 1);
        run_op("sll",      OP_SLL,  32'h1,         32'h21,       32'h2,         1'b0, 1);
        run_op("srl",      OP_SRL,  32'h8000_0000, 32'd31,       32'h1,         1'b0, 1);
        run_op("lt",       OP_LT,   32'hFFFF_FFFF, 32'h1,        32'h1,         1'b0, 1);
        run_op("ltu",      OP_LTU,  32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0, 1);
        run_op("nop",      OP_NOP,  32'h1234,      32'h5678,     32'h0,         1'b0, 1);
        run_op("mulh",     OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        run_op("mulhu",    OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("mul",      OP_MUL,  32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFF1, 1'b0, 33);
        run_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("undef",    5'h1F,   32'h55,        32'h66,       32'h0,         1'b1, 1);
`ifdef ALU_MD_DIV_EN
        run_op("div_z",    OP_DIV,  32'd7,         32'd0,        32'hFFFF_FFFF, 1'b0, DL);
        run_op("remu_z",   OP_REMU, 32'd7,         32'd0,        32'd7,         1'b0, DL);
        run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, DL);
        run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1'b0, DL);
        run_op("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, DL);
        run_op("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, DL);
        run_op("divu",     OP_DIVU, 32'd100,       32'd7,        32'd14,        1'b0, DL);
        run_op("remu",     OP_REMU, 32'd100,       32'd7,        32'd2,         1'b0, DL);
`else
        run_op("div_off",  OP_DIV,  32'd7,         32'd0,        32'h0,         1'b1, DL);
        run_op("remu_off", OP_REMU, 32'd7,         32'd0,        32'h0,         1'b1, DL);
`endif

        // Consumer stall: result held, no new accept, then back-to-back accept.
        out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; in1 = 32'd5; in2 = 32'd6;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_out", out, 32'd11);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op = OP_ADD; in1 = 32'd1; in2 = 32'd2;
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_out", out, 32'd3);
        @(posedge clk); #1;

        // Flush at iteration 10 of an iterative op.
`ifdef ALU_MD_DIV_EN
        op = OP_DIVU;
`else
        op = OP_MULHU;
`endif
        in_valid = 1'b1; in1 = 32'd100; in2 = 32'd7;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_idle", in_ready, 1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
        chk("flush_no_result", seen, 0);
        @(posedge clk); #1;

        // Flush beats a same-cycle accept.
        in_valid = 1'b1; flush = 1'b1; op = OP_ADD; in1 = 32'd9; in2 = 32'd9;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_prio_valid", out_valid, 0);
        @(posedge clk); #1;

        // Back-to-back stream of mixed ops, values checked by the scoreboard.
        bo[0] = OP_ADD; bo[1] = OP_MUL; bo[2] = OP_XOR;
        bo[3] = OP_DIVU; bo[4] = OP_SRA; bo[5] = OP_REM;
        out_ready = 1'b1;
        foreach (bo[i]) begin
            in_valid = 1'b1; op = bo[i]; in1 = $urandom; in2 = $urandom;
            k = 0;
            do begin @(negedge clk); k++; end while (!in_ready && k < 100);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin @(negedge clk); k++; end
        chk("stream_drain", exp_q.size(), 0);
        @(posedge clk); #1;

        // Reset pulsed in the middle of a multiply.
        in_valid = 1'b1; op = OP_MUL; in1 = 32'd123; in2 = 32'd456;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_out", out, 0);
        chk("rst_mid_err", err, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
        chk("rst_mid_no_result", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter OP_W, default 5, opcode width; fixed by package.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted when in_valid & in_ready at the clock edge.
REQ-007 SHALL have ports in1 and in2, input, WIDTH each, operands.
REQ-008 SHALL have port op, input, OP_W, operation code (see REQ-013).
REQ-009 SHALL have port flush, input, 1, abort in-flight op.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer takes the result when out_valid & out_ready at the clock edge.
REQ-012 SHALL have ports out, output, WIDTH, result; and err, output, 1, undefined-op flag.

Function
REQ-013 SHALL support these ops:
- 1-cycle: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, LT, LTU, NOP.
- iterative: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE:
- IDLE->DONE on accept of a 1-cycle op.
- IDLE->BUSY on accept of an iterative op.
- BUSY->DONE after the final iteration.
- DONE->IDLE on out handshake without a new accept.
REQ-015 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready); accept in DONE with handshake SHALL load the new op in the same edge (back-to-back, no bubble).
REQ-016 SHALL give latency 1 cycle (accept edge to out_valid) for 1-cycle ops and WIDTH+1 cycles for iterative ops (radix-2 shift-add multiply, restoring divide).
REQ-017 SHALL use only in2[log2(WIDTH)-1:0] as the shift amount; SRA SHALL be arithmetic.
REQ-018 SHALL return LT/LTU as zero-extended 1 or 0.
REQ-019 SHALL compute MULH/MULHSU/MULHU as the upper WIDTH bits of the 2*WIDTH product (signed*signed, signed*unsigned, unsigned*unsigned) and MUL as the lower WIDTH bits.
REQ-020 SHALL, on divide by zero, return quotient all-ones and remainder = in1, with no exception.
REQ-021 SHALL, on signed overflow (in1 = most-negative, in2 = -1), return DIV = in1 and REM = 0.
REQ-022 SHALL register out and err and hold them stable while out_valid & !out_ready.
REQ-023 SHALL, for an undefined op, return out = 0 and err = 1 with 1-cycle latency; err = 0 otherwise.
REQ-024 SHALL, on flush, return to IDLE at the next edge with out_valid = 0 and discard any result; flush SHALL take priority over a same-cycle accept.
REQ-025 SHALL latch operands at accept; changes on in1/in2/op while BUSY SHALL have no effect.

Reset
REQ-026 SHALL, while rst_n = 0, set state IDLE, out_valid 0, out 0, err 0 and the iteration counter 0; in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-027 SHALL, on reset mid-iteration, abort and lose the operation with no output.

Configuration
REQ-028 SHALL use macro ALU_MD_DIV_EN:
- defined: DIV/DIVU/REM/REMU as specified.
- undefined: divider logic absent; those opcodes SHALL be treated as undefined (REQ-023); multiply unaffected.

Structure
REQ-029 SHALL take from shared package alu_pkg: the opcode enum (OP_W = 5, values ADD..REMU), the state enum and the div-by-zero/overflow result constants.
REQ-030 SHALL place the iterative multiply/divide datapath in one sub-module, md_iter (start/done, operands, sign controls, WIDTH-cycle counter); alu_md owns the FSM, handshake and 1-cycle ops.

Verification (WIDTH=32)
REQ-031 SHALL check: ADD 0xFFFFFFFF + 1 -> out 0 one cycle after accept; SRA 0x80000000 by in2 = 0x24 -> 0xF8000000 (shift amount 4).
REQ-032 SHALL check: MULH 0x80000000 * 0x80000000 -> 0x40000000 and MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE, each at 33 cycles.
REQ-033 SHALL check: DIV 7 / 0 -> 0xFFFFFFFF; REMU 7 % 0 -> 7; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-034 SHALL check: with out_ready low for 5 cycles, out is held and in_ready = 0; then out_ready and in_valid are high together -> new ADD accepted in the same edge, next result valid on the following cycle.
REQ-035 SHALL check: flush at iteration 10 of DIVU -> no out_valid, IDLE next cycle; rst_n pulsed mid-MUL -> all outputs 0.
REQ-036 SHALL check: op = 0x1F -> out 0, err 1; with ALU_MD_DIV_EN undefined, DIV -> err 1.
